// File: rtl/serial_pkg.sv
// serial_pkg: shared constants for the PISO transmitter and matching SIPO receiver
package serial_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
  localparam int SER_WIDTH = 8;
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: shift register with bit counter and first/last-bit flags
module piso_shift_core #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit,
  output logic             o_first,
  output logic             o_last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= (MSB_FIRST != 0) ? r_sr << 1 : r_sr >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_bit   = (MSB_FIRST != 0) ? r_sr[WIDTH-1] : r_sr[0];
  assign o_first = r_cnt == '0;
  assign o_last  = r_cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer_tx.sv
// piso_serializer_tx: parallel-to-serial transmitter with one-word holding register
module piso_serializer_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);
  state_e           r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             w_bit, w_first, w_last_bit, w_shifting, w_accept, w_end, w_load_sr;
  assign w_shifting = r_state == ST_SHIFT;
  assign ready      = !reset && !r_hold_full;
  assign w_accept   = load && ready;
  assign w_end      = w_shifting && w_last_bit;
  // Shifter reloads from idle, or back-to-back on the last bit from hold or a direct accept
  assign w_load_sr  = (!w_shifting && w_accept) || (w_end && (r_hold_full || w_accept));
  piso_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load_sr),
    .i_shift (w_shifting && !w_last_bit),
    .i_data  (r_hold_full ? r_hold : parallel_in),
    .o_bit   (w_bit),
    .o_first (w_first),
    .o_last  (w_last_bit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_load_sr) r_state <= ST_SHIFT;
      else if (w_end) r_state <= ST_IDLE;
      if (w_end && r_hold_full) begin
        r_hold      <= '0;
        r_hold_full <= 1'b0;
      end else if (w_shifting && !w_last_bit && w_accept) begin
        r_hold      <= parallel_in;
        r_hold_full <= 1'b1;
      end
    end
  end
  assign serial_valid = w_shifting;
  assign serial_out   = w_shifting && w_bit;
  assign frame_start  = w_shifting && w_first;
  assign busy         = w_shifting || r_hold_full;
endmodule
